// File: rtl/data_mem_unit_pkg.sv
// Shared constants for the data-memory stage: the memory-mapped I/O page
// addresses, STATUS bit positions and the default RAM depth.
package data_mem_unit_pkg;

    localparam int DEFAULT_DEPTH = 64;

    localparam logic [7:0] ADDR_CYCLE   = 8'hFC;
    localparam logic [7:0] ADDR_STATUS  = 8'hFD;
    localparam logic [7:0] ADDR_PORTIN  = 8'hFE;
    localparam logic [7:0] ADDR_PORTOUT = 8'hFF;

    localparam int STATUS_IN_CHANGED_BIT = 0;
    localparam int STATUS_FAULT_BIT      = 1;

endpackage

// File: rtl/data_mem_unit_in_sync_detect.sv
// PortIn synchronizer chain plus change detection; in_changed stays set
// until software reads the PORTIN location.
module in_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] PortIn,
    input  logic       clr,
    output logic [7:0] sync_out,
    output logic       in_changed
);

    logic [7:0] sync_chain [SYNC_STAGES];
    logic [7:0] prev_sample;

    // A new change arriving in the same cycle as the clearing read must win,
    // otherwise software could silently miss an input transition.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
            prev_sample <= '0;
            in_changed  <= 1'b0;
        end else begin
            sync_chain[0] <= PortIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            prev_sample <= sync_chain[SYNC_STAGES-1];
            if (sync_chain[SYNC_STAGES-1] != prev_sample) begin
                in_changed <= 1'b1;
            end else if (clr) begin
                in_changed <= 1'b0;
            end
        end
    end

    assign sync_out = sync_chain[SYNC_STAGES-1];

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: zero-latency load path over a small RAM plus an I/O page
// (cycle counter, status/fault, synchronized input port, output port).
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [DATA_W-1:0] RAMResult,
    input  logic [DATA_W-1:0] PortIn,
    output logic [DATA_W-1:0] PortOut,
    output logic              Fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [7:0]        cycle_cnt;
    logic [DATA_W-1:0] port_out_q;
    logic              fault_q;

    logic              is_ram;
    logic              mapped;
    logic [AW-1:0]     ram_idx;
    logic              fault_set;
    logic              fault_clr;
    logic              in_clr;
    logic [7:0]        sync_out;
    logic              in_changed;
    logic [DATA_W-1:0] status_word;

    // Address decode; the RAM index is forced to 0 off-range so the array
    // is never addressed beyond DEPTH-1.
    always_comb begin
        is_ram    = ({1'b0, Address} < 9'(DEPTH));
        mapped    = is_ram || (Address >= ADDR_CYCLE);
        ram_idx   = is_ram ? Address[AW-1:0] : '0;
        fault_set = ((MemRead || MemWrite) && !mapped) || (MemRead && MemWrite);
        fault_clr = MemWrite && (Address == ADDR_STATUS);
        in_clr    = MemRead && (Address == ADDR_PORTIN);
    end

    always_comb begin
        status_word                        = '0;
        status_word[STATUS_FAULT_BIT]      = fault_q;
        status_word[STATUS_IN_CHANGED_BIT] = in_changed;
    end

    in_sync_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_in_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .PortIn    (PortIn),
        .clr       (in_clr),
        .sync_out  (sync_out),
        .in_changed(in_changed)
    );

    // Loads read current state only, so a simultaneous store shows the old value.
    always_comb begin
        RAMResult = '0;
        if (MemRead) begin
            case (Address)
                ADDR_CYCLE:   RAMResult = cycle_cnt;
                ADDR_STATUS:  RAMResult = status_word;
                ADDR_PORTIN:  RAMResult = sync_out;
                ADDR_PORTOUT: RAMResult = port_out_q;
                default: begin
                    if (is_ram) begin
                        RAMResult = mem[ram_idx];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite && is_ram) begin
            mem[ram_idx] <= WriteData;
        end
    end

    // A fault raised in the same cycle as the STATUS-write clear must stick.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cycle_cnt  <= '0;
            port_out_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 8'd1;
            if (MemWrite && (Address == ADDR_PORTOUT)) begin
                port_out_q <= WriteData;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end else if (fault_clr) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign PortOut = port_out_q;
    assign Fault   = fault_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_data_mem_unit;
    import data_mem_unit_pkg::*;

    localparam int DEPTH = 64;
    localparam int SYNC  = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Address;
    logic [7:0] WriteData;
    logic       MemWrite;
    logic       MemRead;
    logic [7:0] RAMResult;
    logic [7:0] PortIn;
    logic [7:0] PortOut;
    logic       Fault;

    data_mem_unit #(
        .DEPTH      (DEPTH),
        .DATA_W     (8),
        .SYNC_STAGES(SYNC)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .RAMResult(RAMResult),
        .PortIn   (PortIn),
        .PortOut  (PortOut),
        .Fault    (Fault)
    );

    always #5 Clk = ~Clk;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: memory contents, I/O registers and the history of
    // PortIn samples taken at each edge (index 0 = most recent).
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_out;
    logic [7:0] m_cycle;
    logic       m_fault;
    logic       m_chg;
    logic [7:0] m_hist [SYNC+1];
    bit         started = 1'b0;
    logic [7:0] next_pin = 8'h00;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic rd, input logic [7:0] addr);
        if (!rd) return 8'h00;
        if (int'(addr) < DEPTH) return m_mem[int'(addr)];
        case (addr)
            ADDR_CYCLE:   return m_cycle;
            ADDR_STATUS:  return {6'b0, m_fault, m_chg};
            ADDR_PORTIN:  return m_hist[SYNC-1];
            ADDR_PORTOUT: return m_out;
            default:      return 8'h00;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (!Reset) begin
            started = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            for (int i = 0; i <= SYNC; i++) m_hist[i] = 8'h00;
            m_out   = 8'h00;
            m_cycle = 8'h00;
            m_fault = 1'b0;
            m_chg   = 1'b0;
        end else if (started) begin
            logic mapped_acc;
            mapped_acc = (int'(Address) < DEPTH) || (Address >= 8'hFC);
            if (((MemRead || MemWrite) && !mapped_acc) || (MemRead && MemWrite)) m_fault = 1'b1;
            else if (MemWrite && Address == ADDR_STATUS) m_fault = 1'b0;
            if (m_hist[SYNC-1] != m_hist[SYNC]) m_chg = 1'b1;
            else if (MemRead && Address == ADDR_PORTIN) m_chg = 1'b0;
            if (MemWrite && int'(Address) < DEPTH) m_mem[int'(Address)] = WriteData;
            if (MemWrite && Address == ADDR_PORTOUT) m_out = WriteData;
            m_cycle = m_cycle + 8'd1;
            for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = PortIn;
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            checkOutput("RAMResult", RAMResult, model_read(MemRead, Address));
            checkOutput("PortOut", PortOut, m_out);
            checkOutput("Fault", {7'b0, Fault}, {7'b0, m_fault});
        end
    end

    task automatic applyStimulus(input logic rst_n, input logic rd, input logic wr,
                                 input logic [7:0] addr, input logic [7:0] wd);
        @(posedge Clk);
        #2;
        Reset     = rst_n;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wd;
        PortIn    = next_pin;
    endtask

    initial begin
        Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 8'h00; WriteData = 8'h00; PortIn = 8'h00;
        @(negedge Clk);

        // Reset clears RAM and counter
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 0, 1, 8'h05, 8'h3C);
        applyStimulus(1, 1, 0, 8'h05, 8'h00);
        #1 checkOutput("ram5_before_reset", RAMResult, 8'h3C);
        applyStimulus(0, 1, 0, 8'h05, 8'h00);
        applyStimulus(0, 1, 1, 8'h05, 8'h77);
        applyStimulus(1, 1, 0, ADDR_CYCLE, 8'h00);
        #1 checkOutput("cycle_first", RAMResult, 8'h00);
        applyStimulus(1, 1, 0, ADDR_CYCLE, 8'h00);
        #1 checkOutput("cycle_second", RAMResult, 8'h01);
        applyStimulus(1, 1, 0, 8'h05, 8'h00);
        #1 checkOutput("ram5_after_reset", RAMResult, 8'h00);
        checkOutput("portout_reset", PortOut, 8'h00);
        checkOutput("fault_reset", {7'b0, Fault}, 8'h00);

        // RAM store and load
        applyStimulus(1, 0, 1, 8'h10, 8'hA5);
        applyStimulus(1, 1, 0, 8'h10, 8'h00);
        #1 checkOutput("ram10", RAMResult, 8'hA5);
        applyStimulus(1, 0, 0, 8'h10, 8'h00);
        #1 checkOutput("ram10_noread", RAMResult, 8'h00);
        applyStimulus(1, 0, 1, 8'(DEPTH-1), 8'h11);
        applyStimulus(1, 1, 0, 8'(DEPTH-1), 8'h00);
        #1 checkOutput("ram_top", RAMResult, 8'h11);

        // Output port and synchronized input
        applyStimulus(1, 0, 1, ADDR_PORTOUT, 8'h7E);
        applyStimulus(1, 1, 0, ADDR_PORTOUT, 8'h00);
        #1 checkOutput("portout", PortOut, 8'h7E);
        next_pin = 8'h42;
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        #1 checkOutput("portin_early", RAMResult, 8'h00);
        applyStimulus(1, 1, 0, ADDR_STATUS, 8'h00);
        #1 checkOutput("status_pre", RAMResult, 8'h00);
        applyStimulus(1, 1, 0, ADDR_STATUS, 8'h00);
        #1 checkOutput("status_changed", RAMResult, 8'h01);
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        #1 checkOutput("portin_42", RAMResult, 8'h42);
        applyStimulus(1, 1, 0, ADDR_STATUS, 8'h00);
        #1 checkOutput("status_cleared", RAMResult, 8'h00);

        // Change detection colliding with the clearing read
        next_pin = 8'h99;
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        #1 checkOutput("portin_99", RAMResult, 8'h99);
        applyStimulus(1, 1, 0, ADDR_STATUS, 8'h00);
        #1 checkOutput("status_collide", RAMResult, 8'h01);
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        applyStimulus(1, 1, 0, ADDR_STATUS, 8'h00);
        #1 checkOutput("status_clear2", RAMResult, 8'h00);

        // Faults
        applyStimulus(1, 1, 0, 8'h80, 8'h00);
        #1 checkOutput("unmapped_read", RAMResult, 8'h00);
        applyStimulus(1, 0, 0, 8'h00, 8'h00);
        #1 checkOutput("fault_set", {7'b0, Fault}, 8'h01);
        applyStimulus(1, 0, 1, ADDR_STATUS, 8'hFF);
        applyStimulus(1, 0, 1, 8'h20, 8'h01);
        #1 checkOutput("fault_clear", {7'b0, Fault}, 8'h00);
        applyStimulus(1, 1, 1, 8'h20, 8'h02);
        #1 checkOutput("rdwr_old", RAMResult, 8'h01);
        applyStimulus(1, 1, 0, 8'h20, 8'h00);
        #1 checkOutput("rdwr_new", RAMResult, 8'h02);
        checkOutput("rdwr_fault", {7'b0, Fault}, 8'h01);
        applyStimulus(1, 0, 1, ADDR_STATUS, 8'h00);
        applyStimulus(1, 1, 1, ADDR_STATUS, 8'h00);
        #1 checkOutput("fault_clear2", {7'b0, Fault}, 8'h00);
        applyStimulus(1, 0, 1, ADDR_STATUS, 8'h00);
        #1 checkOutput("fault_set_beats_clear", {7'b0, Fault}, 8'h01);

        // Ignored writes to read-only locations
        applyStimulus(1, 0, 1, ADDR_CYCLE, 8'h55);
        applyStimulus(1, 0, 1, ADDR_PORTIN, 8'h55);
        applyStimulus(1, 1, 0, ADDR_PORTIN, 8'h00);
        #1 checkOutput("portin_ro", RAMResult, 8'h99);
        checkOutput("ro_no_fault", {7'b0, Fault}, 8'h00);

        // Counter wraps after 256 cycles from reset
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) applyStimulus(1, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 1, 0, ADDR_CYCLE, 8'h00);
        #1 checkOutput("cycle_wrap", RAMResult, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [7:0] a;
            logic rd, wr, rst_n;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      a = 8'($urandom_range(0, DEPTH - 1));
            else if (sel <= 7) a = 8'($urandom_range(8'hFC, 8'hFF));
            else               a = 8'($urandom_range(DEPTH, 8'hFB));
            rd    = ($urandom_range(0, 9) < 4);
            wr    = ($urandom_range(0, 9) < 4);
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) next_pin = 8'($urandom);
            applyStimulus(rst_n, rd, wr, a, 8'($urandom));
        end
        applyStimulus(1, 0, 0, 8'h00, 8'h00);
        @(posedge Clk);
        #6;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
